imm_gen_stage: RTL

Parametrised, registered immediate-generation stage for the decode pipeline. It decodes the immediate format directly from the raw instruction, without an external format select. It sign- or zero-extends the immediate to XLEN and precomputes the PC-relative target. Results are presented through a valid/ready interface backed by a one-entry skid buffer, so it sits between fetch and the decode/register-read stage and absorbs one cycle of downstream stall.

---
 rtl/imm_gen_stage_if.sv | 27 ++
 rtl/imm_gen_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bundle between fetch and the immediate-generation stage.
// The slave modport is the stage's view. The master modport is the environment's view.
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate generator: decodes the format from the opcode, extends the immediate,
// and precomputes the PC-relative target behind a one-entry skid buffer.
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst,
  imm_gen_stage_if.slave  bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHAMT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6,
    FMT_CSR   = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt5, shamt6, zimm;

  assign instr    = bus.in_instr;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign shamt5 = XLEN'(instr[24:20]);
  assign shamt6 = XLEN'(instr[25:20]);
  assign zimm   = XLEN'(instr[19:15]);

  entry_t dec;
  logic   pc_rel;

  // NOTE: every field gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    dec.fmt     = FMT_NONE;
    dec.imm     = '0;
    dec.illegal = 1'b0;
    pc_rel      = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
        dec.fmt = FMT_I;
        dec.imm = imm_i;
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          dec.fmt = FMT_SHAMT;
          if (XLEN == 64) begin
            dec.imm = shamt6;
          end else begin
            dec.imm     = shamt5;
            dec.illegal = instr[25];
          end
        end else begin
          dec.fmt = FMT_I;
          dec.imm = imm_i;
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN != 64) begin
          dec.illegal = 1'b1;
        end else if (is_shift) begin
          // Word shifts only take 5 bits even on a 64-bit datapath.
          dec.fmt     = FMT_SHAMT;
          dec.imm     = shamt5;
          dec.illegal = instr[25];
        end else begin
          dec.fmt = FMT_I;
          dec.imm = imm_i;
        end
      end
      OPC_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = imm_s;
      end
      OPC_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = imm_b;
        pc_rel  = 1'b1;
      end
      OPC_LUI: begin
        dec.fmt = FMT_U;
        dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = imm_u;
        pc_rel  = 1'b1;
      end
      OPC_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = imm_j;
        pc_rel  = 1'b1;
      end
      OPC_OP: ;
      OPC_OP_32: dec.illegal = (XLEN != 64);
      OPC_SYSTEM: begin
        if (funct3 != 3'b000) begin
          dec.fmt = FMT_CSR;
          dec.imm = funct3[2] ? zimm : '0;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.target = bus.in_pc + (pc_rel ? dec.imm : XLEN'(4));
  end

  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   accept, issue;

  assign accept = bus.in_valid && !skid_valid_q;
  assign issue  = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || issue) begin
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
    end
  end

  // NOTE: skid payload needs no reset; it is only read while skid_valid_q is set.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_target  = out_q.target;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;

endmodule
